// File: rtl/led_tx_pkg.sv
// Shared types and helpers for the LED strip frame transmitter.
package led_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    SHIFT,
    TAIL
  } tx_state_t;

  function automatic int unsigned bits_per_led(input int unsigned cw, input int unsigned pad);
    return 3 * (cw + pad);
  endfunction

endpackage

// File: rtl/led_sync_fifo.sv
// First-word fall-through synchronous FIFO with occupancy, flush and an
// empty-bypass so a word pushed in the same cycle as a pop is delivered directly.
module led_sync_fifo #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             wr_en;
  logic             rd_en;
  logic             bypass;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  // Empty + push + pop: the incoming word goes straight out and is never stored.
  assign bypass  = empty && push && pop;
  assign wr_en   = push && !full && !bypass && !flush;
  assign rd_en   = pop && !empty && !flush;
  assign rd_data = empty ? wr_data : mem[rptr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr_en) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_en) begin
        rptr <= rptr + 1'b1;
      end
      if (wr_en && !rd_en) begin
        level <= level + 1'b1;
      end else if (rd_en && !wr_en) begin
        level <= level - 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_stream_tx.sv
// LED strip frame transmitter: buffers {R,G,B} pixel words and serialises one
// frame per frame_go onto a divided clock/data pair with idle lead-in and tail.
module led_stream_tx
  import led_tx_pkg::*;
#(
  parameter int unsigned CW       = 4,
  parameter int unsigned PAD      = 4,
  parameter int unsigned LED_NUM  = 47,
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned DIV_CNT  = 5,
  parameter int unsigned WAIT_CNT = 5
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [3*CW-1:0]          s_data,
  input  logic                     frame_go,
  input  logic                     msb_first,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     done,
  output logic                     underrun,
  output logic                     cko_o,
  output logic                     sdo_o
);

  localparam int unsigned BPL  = bits_per_led(CW, PAD);
  localparam int unsigned HALF = DIV_CNT / 2;
  localparam int unsigned DW   = $clog2(DIV_CNT);
  localparam int unsigned BMAX = (BPL > WAIT_CNT) ? BPL : WAIT_CNT;
  localparam int unsigned BCW  = $clog2(BMAX + 1);
  localparam int unsigned PW   = $clog2(LED_NUM + 1);

  tx_state_t          state, state_n;
  logic [DW-1:0]      div, div_n;
  logic [BCW-1:0]     bitc, bitc_n;
  logic [PW-1:0]      pix, pix_n;
  logic [BPL-1:0]     shreg, shreg_n;
  logic               order, order_n;
  logic               underrun_n;
  logic               done_n;
  logic               cko_n;
  logic               sdo_n;
  logic               load;
  logic               period_end;

  logic [3*CW-1:0]    fifo_data;
  logic               fifo_full;
  logic               fifo_empty;
  logic               avail;
  logic [3*CW-1:0]    head;
  logic [BPL-1:0]     pixel_bits;

  led_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (3*CW)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push    (s_valid),
    .pop     (load),
    .flush   (flush && (state == IDLE)),
    .wr_data (s_data),
    .rd_data (fifo_data),
    .level   (level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign s_ready = !fifo_full;
  assign busy    = (state != IDLE);
  assign avail   = !fifo_empty || (s_valid && !fifo_full);

  // Serialised pixel image, transmitted from bit BPL-1 downwards; pads default to 1.
  always_comb begin
    pixel_bits = '1;
    head       = avail ? fifo_data : '0;
    for (int unsigned ch = 0; ch < 3; ch++) begin
      for (int unsigned i = 0; i < CW; i++) begin
        pixel_bits[BPL-1-(ch*(CW+PAD)+i)] = order ? head[(2-ch)*CW + (CW-1-i)]
                                                  : head[(2-ch)*CW + i];
      end
    end
  end

  always_comb begin
    state_n    = state;
    div_n      = div;
    bitc_n     = bitc;
    pix_n      = pix;
    shreg_n    = shreg;
    order_n    = order;
    underrun_n = underrun;
    done_n     = 1'b0;
    load       = 1'b0;
    period_end = (div == DW'(DIV_CNT-1));

    if (state != IDLE) begin
      div_n = period_end ? '0 : div + 1'b1;
    end

    case (state)
      IDLE: begin
        if (frame_go) begin
          state_n    = LEAD;
          div_n      = '0;
          bitc_n     = '0;
          order_n    = msb_first;
          underrun_n = 1'b0;
        end
      end
      LEAD: begin
        if (period_end) begin
          if (bitc == BCW'(WAIT_CNT-1)) begin
            state_n = SHIFT;
            bitc_n  = '0;
            pix_n   = '0;
            load    = 1'b1;
          end else begin
            bitc_n = bitc + 1'b1;
          end
        end
      end
      SHIFT: begin
        if (period_end) begin
          if (bitc == BCW'(BPL-1)) begin
            bitc_n = '0;
            if (pix == PW'(LED_NUM-1)) begin
              state_n = TAIL;
            end else begin
              pix_n = pix + 1'b1;
              load  = 1'b1;
            end
          end else begin
            bitc_n  = bitc + 1'b1;
            shreg_n = shreg << 1;
          end
        end
      end
      TAIL: begin
        if (period_end) begin
          if (bitc == BCW'(WAIT_CNT-1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            bitc_n = bitc + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (load) begin
      shreg_n = pixel_bits;
      if (!avail) begin
        underrun_n = 1'b1;
      end
    end

    // Pins are registered from next-state values so they change exactly at period start.
    cko_n = (state_n == SHIFT) && (div_n >= DW'(HALF));
    sdo_n = (state_n == SHIFT) && shreg_n[BPL-1];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      div      <= '0;
      bitc     <= '0;
      pix      <= '0;
      shreg    <= '0;
      order    <= 1'b0;
      underrun <= 1'b0;
      done     <= 1'b0;
      cko_o    <= 1'b0;
      sdo_o    <= 1'b0;
    end else begin
      state    <= state_n;
      div      <= div_n;
      bitc     <= bitc_n;
      pix      <= pix_n;
      shreg    <= shreg_n;
      order    <= order_n;
      underrun <= underrun_n;
      done     <= done_n;
      cko_o    <= cko_n;
      sdo_o    <= sdo_n;
    end
  end

endmodule

// File: tb/tb_led_stream_tx.sv
// Bench for led_stream_tx: frame-level reference model checked every cycle,
// plus literal expectations on bit patterns, latency, levels and flags.
module tb_led_stream_tx;

  localparam int unsigned CW    = 4;
  localparam int unsigned PAD   = 4;
  localparam int unsigned N     = 47;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned D     = 5;
  localparam int unsigned W     = 5;
  localparam int unsigned B     = 3 * (CW + PAD);
  localparam int unsigned F     = (2 * W + N * B) * D;

  logic                     clk = 1'b0;
  logic                     rstn = 1'b0;
  logic                     s_valid = 1'b0;
  logic                     s_ready;
  logic [3*CW-1:0]          s_data = '0;
  logic                     frame_go = 1'b0;
  logic                     msb_first = 1'b1;
  logic                     flush = 1'b0;
  logic [$clog2(DEPTH):0]   level;
  logic                     busy;
  logic                     done;
  logic                     underrun;
  logic                     cko_o;
  logic                     sdo_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  logic [3*CW-1:0] q [$];
  logic [3*CW-1:0] m_pix [N];
  bit              m_busy = 1'b0;
  bit              m_done = 1'b0;
  bit              m_underrun = 1'b0;
  bit              m_order = 1'b0;
  int unsigned     m_k = 0;

  led_stream_tx #(
    .CW       (CW),
    .PAD      (PAD),
    .LED_NUM  (N),
    .DEPTH    (DEPTH),
    .DIV_CNT  (D),
    .WAIT_CNT (W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .frame_go  (frame_go),
    .msb_first (msb_first),
    .flush     (flush),
    .level     (level),
    .busy      (busy),
    .done      (done),
    .underrun  (underrun),
    .cko_o     (cko_o),
    .sdo_o     (sdo_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Frame timeline: cycle m_k (1..F) of the frame; period = (m_k-1)/D.
  function automatic logic in_data();
    int unsigned per;
    if (!m_busy) return 1'b0;
    per = (m_k - 1) / D;
    return (per >= W) && (per < W + N * B);
  endfunction

  function automatic logic exp_cko();
    if (!in_data()) return 1'b0;
    return ((m_k - 1) % D) >= (D / 2);
  endfunction

  function automatic logic exp_sdo();
    int unsigned per, qb, idx, b, ch, pos;
    logic [3*CW-1:0] w;
    logic [CW-1:0]   chan;
    if (!in_data()) return 1'b0;
    per = (m_k - 1) / D;
    qb  = per - W;
    idx = qb / B;
    b   = qb % B;
    ch  = b / (CW + PAD);
    pos = b % (CW + PAD);
    if (pos >= CW) return 1'b1;
    w    = m_pix[idx];
    chan = CW'(w >> ((2 - ch) * CW));
    return m_order ? chan[CW-1-pos] : chan[pos];
  endfunction

  initial begin : model
    int unsigned p;
    bit push;
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        q.delete();
        m_busy     = 1'b0;
        m_done     = 1'b0;
        m_underrun = 1'b0;
        m_k        = 0;
      end else begin
        push   = s_valid && (q.size() < DEPTH);
        m_done = 1'b0;
        if (!m_busy) begin
          if (flush) q.delete();
          else if (push) q.push_back(s_data);
          if (frame_go) begin
            m_busy     = 1'b1;
            m_k        = 1;
            m_order    = msb_first;
            m_underrun = 1'b0;
          end
        end else begin
          if (push) q.push_back(s_data);
          if (m_k % D == 0) begin
            p = m_k / D;
            if (p >= W && p < W + N * B && (p - W) % B == 0) begin
              if (q.size() > 0) m_pix[(p - W) / B] = q.pop_front();
              else begin
                m_pix[(p - W) / B] = '0;
                m_underrun = 1'b1;
              end
            end
          end
          if (m_k == F) begin
            m_busy = 1'b0;
            m_done = 1'b1;
          end else begin
            m_k++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("s_ready", s_ready, q.size() < DEPTH);
      chk("level", level, q.size());
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("underrun", underrun, m_underrun);
      chk("cko_o", cko_o, exp_cko());
      chk("sdo_o", sdo_o, exp_sdo());
    end
    if (done) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int target);
    do @(negedge clk); while (cyc < target);
  endtask

  task automatic preload(input int n, input logic [3*CW-1:0] first);
    for (int i = 0; i < n; i++) begin
      step();
      s_valid = 1'b1;
      s_data  = (i == 0) ? first : (3*CW)'($urandom);
    end
    step();
    s_valid = 1'b0;
  endtask

  task automatic go(input logic order, output int t);
    step();
    frame_go  = 1'b1;
    msb_first = order;
    t = cyc;
    step();
    frame_go = 1'b0;
  endtask

  task automatic capture(input int t, output logic [23:0] bits);
    bits = '0;
    for (int i = 0; i < 24; i++) begin
      wait_cyc(t + 1 + W * D + i * D + 2);
      bits = {bits[22:0], sdo_o};
    end
  endtask

  task automatic wait_done(input int t, output int lat);
    int n;
    n = 0;
    lat = -1;
    while (n < 6000) begin
      @(negedge clk);
      n++;
      if (done) begin
        lat = cyc - t;
        break;
      end
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [23:0] bits;
    int t, lat, dn0;

    step();
    chk_en = 1'b1;
    step();
    @(negedge clk);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_cko", cko_o, 0);
    chk("rst_sdo", sdo_o, 0);
    step();
    rstn = 1'b1;

    // Full frame, MSB first
    preload(47, 12'hA5F);
    go(1'b1, t);
    capture(t, bits);
    chk("msb_bits", bits, 24'b1010_1111_0101_1111_1111_1111);
    wait_done(t, lat);
    chk("msb_done_latency", lat, 5691);
    @(negedge clk);
    chk("msb_underrun", underrun, 0);
    chk("msb_level", level, 0);

    // Full frame, LSB first, with frame_go and flush pulsed mid-frame
    preload(47, 12'hA5F);
    go(1'b0, t);
    capture(t, bits);
    chk("lsb_bits", bits, 24'b0101_1111_1010_1111_1111_1111);
    dn0 = done_cnt;
    wait_cyc(t + 2000);
    step();
    frame_go = 1'b1;
    flush    = 1'b1;
    step();
    frame_go = 1'b0;
    flush    = 1'b0;
    @(negedge clk);
    chk("midflush_level_kept", level != 0, 1);
    wait_done(t, lat);
    chk("lsb_done_latency", lat, 5691);
    repeat (20) step();
    chk("single_done", done_cnt - dn0, 1);
    chk("lsb_level", level, 0);

    // Underrun: only 10 words for a 47-pixel frame
    preload(10, 12'h123);
    go(1'b1, t);
    wait_done(t, lat);
    chk("ur_done_latency", lat, 5691);
    @(negedge clk);
    chk("ur_set", underrun, 1);
    repeat (50) step();
    chk("ur_sticky", underrun, 1);

    // Overfill while idle, then flush
    for (int i = 0; i < 70; i++) begin
      step();
      s_valid = 1'b1;
      s_data  = 12'(i);
    end
    step();
    s_valid = 1'b0;
    @(negedge clk);
    chk("full_level", level, 64);
    chk("full_s_ready", s_ready, 0);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_level", level, 0);
    chk("flush_s_ready", s_ready, 1);
    chk("ur_still_sticky", underrun, 1);

    // Reset in the middle of SHIFT
    preload(47, 12'h3C9);
    go(1'b1, t);
    @(negedge clk);
    chk("go_clears_underrun", underrun, 0);
    wait_cyc(t + 1003);
    step();
    rstn = 1'b0;
    #1;
    chk("arst_cko", cko_o, 0);
    chk("arst_sdo", sdo_o, 0);
    chk("arst_busy", busy, 0);
    chk("arst_level", level, 0);
    repeat (3) step();
    rstn = 1'b1;

    // Clean frame after reset release
    preload(47, 12'hA5F);
    go(1'b1, t);
    capture(t, bits);
    chk("post_rst_bits", bits, 24'b1010_1111_0101_1111_1111_1111);
    wait_done(t, lat);
    chk("post_rst_latency", lat, 5691);
    @(negedge clk);
    chk("post_rst_level", level, 0);
    chk("post_rst_underrun", underrun, 0);
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
